// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   - ALU control codes understood by the external ALU
//   - legal-op check used to flag bad requests
//   - arbiter FSM state encoding
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant, purely combinational.
//   valid : request valid per input
//   prio  : index that wins when both inputs are valid
//   any   : at least one input valid
//   win   : index of the winning input (meaningful only when any=1)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       any,
  output logic       win
);

  assign any = |valid;
  // A lone requester always wins; prio only breaks ties.
  assign win = (&valid) ? prio : valid[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters.
// One transaction in flight: IDLE (accept) -> EXEC (ALU evaluates) ->
// RESP (hold response until the granted requester takes it).
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake, bit i = requester i
//   req_op/req_a/req_b  : packed per-requester op code and operands
//   resp_valid/ready    : response handshake, bit i = requester i
//   resp_result/zero/err: shared response bus for the granted requester
//   alu_data1/2, ctrl   : registered drive to the ALU
//   alu_result, alu_zero: ALU outputs, captured at the end of EXEC
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      alu_data1,
  output logic [WIDTH-1:0]      alu_data2,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero
);

  state_t state;
  logic   prio;
  logic   grant;
  logic   any;
  logic   win;

  rr_arb2 u_arb (
    .valid (req_valid[1:0]),
    .prio  (prio),
    .any   (any),
    .win   (win)
  );

  // Winner's request fields, selected for latching in the accept cycle.
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  assign sel_op = win ? req_op[7:4]            : req_op[3:0];
  assign sel_a  = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b  = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  // Accept strobe only in IDLE; forced low while reset is held so a
  // requester cannot see a phantom accept.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any) req_ready[win] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[grant] = 1'b1;
  end

  // The alu_* registers double as the latched request: they are loaded
  // at accept and stay put through EXEC, so the ALU sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant       <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_ctrl    <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          alu_ctrl  <= sel_op;
          alu_data1 <= sel_a;
          alu_data2 <= sel_b;
          grant     <= win;
          state     <= EXEC;
        end
        EXEC: begin
          // Illegal ops ignore whatever the ALU produced.
          if (is_legal_op(alu_ctrl)) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_err    <= 1'b0;
          end else begin
            resp_result <= '0;
            resp_zero   <= 1'b1;
            resp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: if (resp_ready[grant]) begin
          prio  <= ~grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [7:0]    req_op;
  logic [2*W-1:0] req_a, req_b;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [W-1:0]  resp_result;
  logic          resp_zero, resp_err;
  logic [W-1:0]  alu_data1, alu_data2;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  alu_result;
  logic          alu_zero;

  int n_cmp = 0;
  int n_err = 0;
  int ref_prio = 0;

  alu_share_arbiter #(.WIDTH(W), .NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // External ALU stand-in; returns junk on unknown codes so the
  // arbiter's override of illegal-op results is observable.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_ctrl)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_data1 | alu_data2);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Reference: what the requester should get back for (op, a, b).
  task automatic ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic e);
    e = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = W'(a + b);
      4'd6:  r = W'(a - b);
      4'd7:  r = (a < b) ? 1 : 0;
      4'd12: r = ~(a | b);
      default: begin r = 0; e = 1'b1; end
    endcase
    z = (r == 0);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[4*i +: 4] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  // Runs one transaction from IDLE. Called just after a rising edge with
  // req_valid already set. hold = cycles resp_ready[win] stays low;
  // inject = raise req0 valid during the hold (must be ignored).
  task automatic serve(input int hold, input bit inject, input bit noise);
    int win;
    logic [1:0] oh;
    logic [3:0] op;
    logic [W-1:0] a, b, er;
    logic ez, ee;
    #1;
    win = (req_valid == 2'b11) ? ref_prio : (req_valid[1] ? 1 : 0);
    oh  = (win == 1) ? 2'b10 : 2'b01;
    op  = req_op[4*win +: 4];
    a   = req_a[W*win +: W];
    b   = req_b[W*win +: W];
    ref_alu(op, a, b, er, ez, ee);
    chk("req_ready_accept", req_ready, oh);
    @(posedge clk); #1;
    req_valid[win] = 1'b0;
    chk("req_ready_exec", req_ready, 2'b00);
    chk("resp_valid_exec", resp_valid, 2'b00);
    chk("alu_ctrl", alu_ctrl, op);
    chk("alu_data1", alu_data1, a);
    chk("alu_data2", alu_data2, b);
    @(posedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", resp_valid, oh);
      chk("resp_result", resp_result, er);
      chk("resp_zero", resp_zero, ez);
      chk("resp_err", resp_err, ee);
      chk("req_ready_resp", req_ready, 2'b00);
      if (h < hold) begin
        if (inject) req_valid[0] = 1'b1;
        if (noise) resp_ready[1-win] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    chk("resp_valid_after", resp_valid, 2'b00);
    ref_prio = 1 - win;
  endtask

  logic [3:0] legal_tbl [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    #12;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_data1", alu_data1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests with prio 0: req0 then req1, prio back at 0.
    set_req(0, 4'b0110, 9, 9);
    set_req(1, 4'b0001, 32'hF0, 32'h0F);
    serve(0, 0, 0);
    serve(0, 0, 0);
    chk("prio_after_pair", ref_prio, 0);

    // Single request.
    set_req(0, 4'b0010, 5, 7);
    serve(0, 0, 0);

    // Backpressure on req1 with a req0 arriving meanwhile.
    req_op[3:0] = 4'b0110; req_a[W-1:0] = 20; req_b[W-1:0] = 3;
    set_req(1, 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    serve(5, 1, 0);
    chk("inject_pending", req_valid, 2'b01);
    serve(0, 0, 0);

    // Illegal op and SLT/NOR corners.
    set_req(1, 4'b0011, 1, 2);
    serve(0, 0, 0);
    set_req(0, 4'b0111, 32'hFFFF_FFFF, 1);
    serve(0, 0, 0);
    set_req(1, 4'b1100, 0, 0);
    serve(0, 0, 0);

    // Leave prio at 1 with a nonzero response, then reset mid-EXEC.
    set_req(0, 4'b0010, 5, 7);
    serve(0, 0, 0);
    set_req(0, 4'b0010, 100, 1);
    #1;
    chk("pre_rst_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 2'b00);
    chk("mid_rst_resp_valid", resp_valid, 2'b00);
    chk("mid_rst_resp_result", resp_result, 0);
    chk("mid_rst_resp_zero", resp_zero, 0);
    chk("mid_rst_resp_err", resp_err, 0);
    chk("mid_rst_alu_ctrl", alu_ctrl, 0);
    chk("mid_rst_alu_data1", alu_data1, 0);
    chk("mid_rst_alu_data2", alu_data2, 0);
    #3 rst_n = 1'b1;
    ref_prio = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", resp_valid, 2'b00);
    end
    set_req(0, 4'b0001, 3, 4);
    set_req(1, 4'b0010, 3, 4);
    serve(0, 0, 0);
    serve(0, 0, 0);

    // Randomized traffic against the reference.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          rop = legal_tbl[$urandom_range(0, 5)];
          if ($urandom_range(0, 5) == 0) rop = 4'($urandom);
          ra = $urandom; rb = $urandom;
          if ($urandom_range(0, 3) == 0) rb = ra;
          set_req(i, rop, ra, rb);
        end
      end
      if (req_valid == 2'b00) set_req(1, 4'b0010, $urandom, $urandom);
      for (int s = 0; s < 2 && req_valid != 2'b00; s++)
        serve($urandom_range(0, 3), 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
